// File: rtl/aeolus_alu_pkg.sv
`default_nettype none
// ============================================================================
// Package     : aeolus_alu_pkg
// Description : Shared definitions for the Aeolus ALU control path: opcode
//               encodings, sequencer state encoding and the bit position of
//               each ALU control strobe inside the strobe vector.
// Revision    : 1.0 - initial release
// ============================================================================
package aeolus_alu_pkg;

  // Opcode encodings (0xB-0xF are undefined)
  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_INV = 4'h6;
  localparam logic [3:0] OP_CLR = 4'h7;
  localparam logic [3:0] OP_LSH = 4'h8;
  localparam logic [3:0] OP_RSH = 4'h9;
  localparam logic [3:0] OP_LDA = 4'hA;

  // Sequencer state encoding
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_EXEC  = 2'd1,
    ST_SHLD  = 2'd2,
    ST_SHIFT = 2'd3
  } state_t;

  // Bit index of each ALU control inside the strobe vector
  localparam int STB_ADD   = 0;
  localparam int STB_SUB   = 1;
  localparam int STB_LSR   = 2;
  localparam int STB_LSH   = 3;
  localparam int STB_RSH   = 4;
  localparam int STB_AND   = 5;
  localparam int STB_OR    = 6;
  localparam int STB_XOR   = 7;
  localparam int STB_INV   = 8;
  localparam int STB_CLR   = 9;
  localparam int STB_COUNT = 10;

endpackage
`default_nettype wire

// File: rtl/alu_op_decoder.sv
`default_nettype none
// ============================================================================
// Module      : alu_op_decoder
// Description : Combinational decode of the latched opcode and the sequencer
//               state into the one-hot ALU strobe vector. Only registered
//               inputs feed this block, so strobes never depend on instr_*.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_op_decoder
  import aeolus_alu_pkg::*;
#(
  parameter int OP_WIDTH = 4
) (
  input  logic [1:0]          state,
  input  logic [OP_WIDTH-1:0] op,
  output logic [9:0]          strobe
);

  // One strobe at most: EXEC selects by opcode, SHLD loads, SHIFT picks direction
  always_comb begin
    strobe = '0;
    case (state)
      ST_EXEC: begin
        if (op == OP_WIDTH'(OP_ADD)) strobe[STB_ADD] = 1'b1;
        if (op == OP_WIDTH'(OP_SUB)) strobe[STB_SUB] = 1'b1;
        if (op == OP_WIDTH'(OP_AND)) strobe[STB_AND] = 1'b1;
        if (op == OP_WIDTH'(OP_OR))  strobe[STB_OR]  = 1'b1;
        if (op == OP_WIDTH'(OP_XOR)) strobe[STB_XOR] = 1'b1;
        if (op == OP_WIDTH'(OP_INV)) strobe[STB_INV] = 1'b1;
        if (op == OP_WIDTH'(OP_CLR)) strobe[STB_CLR] = 1'b1;
      end
      ST_SHLD: strobe[STB_LSR] = 1'b1;
      ST_SHIFT: begin
        if (op == OP_WIDTH'(OP_LSH)) strobe[STB_LSH] = 1'b1;
        else                         strobe[STB_RSH] = 1'b1;
      end
      default: strobe = '0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_control_sequencer
// Description : Issuing side of the ALU one-hot control interface. Accepts
//               opcode/operand words, sequences single-cycle and multi-cycle
//               (shift) operations and captures results into the accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_control_sequencer
  import aeolus_alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OP_WIDTH   = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  instr_valid,
  output logic                  instr_ready,
  input  logic [OP_WIDTH-1:0]   instr_opcode,
  input  logic [DATA_WIDTH-1:0] instr_operand,
  output logic                  alu_add,
  output logic                  alu_sub,
  output logic                  alu_lsr,
  output logic                  alu_lsh,
  output logic                  alu_rsh,
  output logic                  alu_and,
  output logic                  alu_or,
  output logic                  alu_xor,
  output logic                  alu_inv,
  output logic                  alu_clr,
  output logic [DATA_WIDTH-1:0] alu_in1,
  output logic [DATA_WIDTH-1:0] alu_in2,
  input  logic [DATA_WIDTH-1:0] alu_out,
  input  logic                  alu_overflow,
  input  logic                  alu_shift_flag,
  output logic [DATA_WIDTH-1:0] acc,
  output logic                  ovf_flag,
  output logic                  shf_flag,
  output logic                  busy,
  output logic                  illegal
);

  state_t                  state_q, state_d;
  logic [OP_WIDTH-1:0]     op_q, op_d;
  logic [DATA_WIDTH-1:0]   opnd_q, opnd_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   acc_q, acc_d;
  logic                    ovf_q, ovf_d;
  logic                    shf_q, shf_d;
  logic                    illegal_q, illegal_d;
  logic [9:0]              strobe;

  // State and datapath registers; reset discards any in-flight operation
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      op_q      <= '0;
      opnd_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
      shf_q     <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      opnd_q    <= opnd_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
      shf_q     <= shf_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, handshake acceptance and result writeback
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    opnd_d    = opnd_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    ovf_d     = ovf_q;
    shf_d     = shf_q;
    illegal_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          op_d   = instr_opcode;
          opnd_d = instr_operand;
          if (instr_opcode == OP_WIDTH'(OP_NOP)) begin
            state_d = ST_IDLE;
          end else if (instr_opcode <= OP_WIDTH'(OP_CLR)) begin
            state_d = ST_EXEC;
          end else if ((instr_opcode == OP_WIDTH'(OP_LSH)) ||
                       (instr_opcode == OP_WIDTH'(OP_RSH))) begin
            state_d = ST_SHLD;
          end else if (instr_opcode == OP_WIDTH'(OP_LDA)) begin
            acc_d = instr_operand;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      ST_EXEC: begin
        acc_d = alu_out;
        if ((op_q == OP_WIDTH'(OP_ADD)) || (op_q == OP_WIDTH'(OP_SUB))) ovf_d = alu_overflow;
        else                                                            ovf_d = 1'b0;
        state_d = ST_IDLE;
      end
      ST_SHLD: begin
        cnt_d   = opnd_q[1:0];
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cnt_q == 2'd0) begin
          acc_d   = alu_out;
          shf_d   = alu_shift_flag;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  alu_op_decoder #(
    .OP_WIDTH (OP_WIDTH)
  ) u_decoder (
    .state  (state_q),
    .op     (op_q),
    .strobe (strobe)
  );

  assign alu_add     = strobe[STB_ADD];
  assign alu_sub     = strobe[STB_SUB];
  assign alu_lsr     = strobe[STB_LSR];
  assign alu_lsh     = strobe[STB_LSH];
  assign alu_rsh     = strobe[STB_RSH];
  assign alu_and     = strobe[STB_AND];
  assign alu_or      = strobe[STB_OR];
  assign alu_xor     = strobe[STB_XOR];
  assign alu_inv     = strobe[STB_INV];
  assign alu_clr     = strobe[STB_CLR];

  assign instr_ready = (state_q == ST_IDLE);
  assign busy        = ~instr_ready;
  assign alu_in1     = acc_q;
  assign alu_in2     = opnd_q;
  assign acc         = acc_q;
  assign ovf_flag    = ovf_q;
  assign shf_flag    = shf_q;
  assign illegal     = illegal_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_control_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_control_sequencer
// Description : Directed self-checking bench for alu_control_sequencer with a
//               simple behavioural ALU (including a load/shift register).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_control_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       instr_valid;
  logic       instr_ready;
  logic [3:0] instr_opcode;
  logic [7:0] instr_operand;
  logic       alu_add, alu_sub, alu_lsr, alu_lsh, alu_rsh;
  logic       alu_and, alu_or, alu_xor, alu_inv, alu_clr;
  logic [7:0] alu_in1, alu_in2, alu_out, acc;
  logic       alu_overflow, alu_shift_flag;
  logic       ovf_flag, shf_flag, busy, illegal;

  int checks = 0;
  int errors = 0;

  localparam logic [9:0] S_NONE = 10'b0000000000;
  localparam logic [9:0] S_ADD  = 10'b0000000001;
  localparam logic [9:0] S_SUB  = 10'b0000000010;
  localparam logic [9:0] S_LSR  = 10'b0000000100;
  localparam logic [9:0] S_LSH  = 10'b0000001000;
  localparam logic [9:0] S_RSH  = 10'b0000010000;
  localparam logic [9:0] S_AND  = 10'b0000100000;
  localparam logic [9:0] S_XOR  = 10'b0010000000;
  localparam logic [9:0] S_INV  = 10'b0100000000;
  localparam logic [9:0] S_CLR  = 10'b1000000000;

  logic [9:0] strb;
  assign strb = {alu_clr, alu_inv, alu_xor, alu_or, alu_and,
                 alu_rsh, alu_lsh, alu_lsr, alu_sub, alu_add};

  alu_control_sequencer #(
    .DATA_WIDTH (8),
    .OP_WIDTH   (4)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_opcode   (instr_opcode),
    .instr_operand  (instr_operand),
    .alu_add        (alu_add),
    .alu_sub        (alu_sub),
    .alu_lsr        (alu_lsr),
    .alu_lsh        (alu_lsh),
    .alu_rsh        (alu_rsh),
    .alu_and        (alu_and),
    .alu_or         (alu_or),
    .alu_xor        (alu_xor),
    .alu_inv        (alu_inv),
    .alu_clr        (alu_clr),
    .alu_in1        (alu_in1),
    .alu_in2        (alu_in2),
    .alu_out        (alu_out),
    .alu_overflow   (alu_overflow),
    .alu_shift_flag (alu_shift_flag),
    .acc            (acc),
    .ovf_flag       (ovf_flag),
    .shf_flag       (shf_flag),
    .busy           (busy),
    .illegal        (illegal)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: combinational ops plus a shifter loaded by alu_lsr
  logic [7:0] sh_q = 8'h00;
  always_comb begin
    alu_out        = 8'h00;
    alu_overflow   = 1'b0;
    alu_shift_flag = 1'b0;
    if (alu_add) {alu_overflow, alu_out} = {1'b0, alu_in1} + {1'b0, alu_in2};
    if (alu_sub) {alu_overflow, alu_out} = {1'b0, alu_in1} - {1'b0, alu_in2};
    if (alu_and) alu_out = alu_in1 & alu_in2;
    if (alu_or)  alu_out = alu_in1 | alu_in2;
    if (alu_xor) alu_out = alu_in1 ^ alu_in2;
    if (alu_inv) alu_out = ~alu_in1;
    if (alu_clr) alu_out = 8'h00;
    if (alu_lsr) alu_out = alu_in1;
    if (alu_lsh) begin alu_out = {sh_q[6:0], 1'b0}; alu_shift_flag = sh_q[7]; end
    if (alu_rsh) begin alu_out = {1'b0, sh_q[7:1]}; alu_shift_flag = sh_q[0]; end
  end
  always_ff @(posedge clk) begin
    if (alu_lsr)                sh_q <= alu_in1;
    else if (alu_lsh | alu_rsh) sh_q <= alu_out;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // At most one strobe in every cycle
  always @(negedge clk) check("onehot", 32'($countones(strb) <= 1), 32'd1);

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a word, wait (bounded) for ready, return #1 after the accept edge
  task automatic send(input logic [3:0] op, input logic [7:0] d);
    int n = 0;
    instr_valid   = 1'b1;
    instr_opcode  = op;
    instr_operand = d;
    while (!instr_ready && n < 20) begin
      step();
      n++;
    end
    if (!instr_ready) check("send_timeout", 32'(instr_ready), 32'd1);
    step();
    instr_valid = 1'b0;
  endtask

  initial begin
    int nb;
    reset         = 1'b0;
    instr_valid   = 1'b0;
    instr_opcode  = 4'h0;
    instr_operand = 8'h00;
    step();
    step();
    // Reset state
    check("rst_strb",  32'(strb), 32'(S_NONE));
    check("rst_acc",   32'(acc), 32'h00);
    check("rst_ready", 32'(instr_ready), 32'd1);
    check("rst_ovf",   32'(ovf_flag), 32'd0);
    check("rst_ill",   32'(illegal), 32'd0);
    reset = 1'b1;
    step();

    // LDA 5, ADD 3
    send(4'hA, 8'h05);
    check("lda_acc", 32'(acc), 32'h05);
    check("lda_strb", 32'(strb), 32'(S_NONE));
    send(4'h1, 8'h03);
    check("add_strb", 32'(strb), 32'(S_ADD));
    check("add_in2",  32'(alu_in2), 32'h03);
    check("add_busy", 32'(busy), 32'd1);
    step();
    check("add_acc",  32'(acc), 32'h08);
    check("add_ovf",  32'(ovf_flag), 32'd0);
    check("add_done", 32'(strb), 32'(S_NONE));

    // Overflowing ADD, then AND clears the overflow
    send(4'hA, 8'hFF);
    send(4'h1, 8'h02);
    step();
    check("addc_acc", 32'(acc), 32'h01);
    check("addc_ovf", 32'(ovf_flag), 32'd1);
    send(4'h3, 8'h0F);
    check("and_strb", 32'(strb), 32'(S_AND));
    step();
    check("and_acc", 32'(acc), 32'h01);
    check("and_ovf", 32'(ovf_flag), 32'd0);

    // SUB with borrow
    send(4'hA, 8'h02);
    send(4'h2, 8'h03);
    check("sub_strb", 32'(strb), 32'(S_SUB));
    step();
    check("sub_acc", 32'(acc), 32'hFF);
    check("sub_ovf", 32'(ovf_flag), 32'd1);

    // LDA 3, LSH by 2+1: 3 -> 6 -> 0x0C -> 0x18
    send(4'hA, 8'h03);
    send(4'h8, 8'h02);
    nb = 0;
    check("shld_strb", 32'(strb), 32'(S_LSR));
    if (busy) nb++;
    for (int i = 0; i < 3; i++) begin
      step();
      check("lsh_strb", 32'(strb), 32'(S_LSH));
      if (busy) nb++;
    end
    step();
    if (busy) nb++;
    check("lsh_busycyc", 32'(nb), 32'd4);
    check("lsh_acc",  32'(acc), 32'h18);
    check("lsh_shf",  32'(shf_flag), 32'd0);
    check("lsh_ovf",  32'(ovf_flag), 32'd1);
    check("lsh_done", 32'(strb), 32'(S_NONE));

    // LDA 0x81, RSH by 0+1: 0x40, shifted-out bit 1
    send(4'hA, 8'h81);
    send(4'h9, 8'h00);
    check("rshld_strb", 32'(strb), 32'(S_LSR));
    step();
    check("rsh_strb", 32'(strb), 32'(S_RSH));
    step();
    check("rsh_acc",   32'(acc), 32'h40);
    check("rsh_shf",   32'(shf_flag), 32'd1);
    check("rsh_ready", 32'(instr_ready), 32'd1);

    // Illegal opcode
    send(4'hC, 8'h55);
    check("ill_pulse", 32'(illegal), 32'd1);
    check("ill_strb",  32'(strb), 32'(S_NONE));
    check("ill_ready", 32'(instr_ready), 32'd1);
    step();
    check("ill_clear", 32'(illegal), 32'd0);
    check("ill_acc",   32'(acc), 32'h40);

    // Valid held during ADD: second word waits for IDLE
    send(4'h1, 8'h01);
    instr_valid   = 1'b1;
    instr_opcode  = 4'h5;
    instr_operand = 8'hFF;
    check("hold_ready0", 32'(instr_ready), 32'd0);
    check("hold_strb",   32'(strb), 32'(S_ADD));
    step();
    check("hold_ready1", 32'(instr_ready), 32'd1);
    check("hold_acc1",   32'(acc), 32'h41);
    step();
    instr_valid = 1'b0;
    check("hold_xor",  32'(strb), 32'(S_XOR));
    step();
    check("hold_acc2", 32'(acc), 32'hBE);
    check("hold_ovf",  32'(ovf_flag), 32'd0);

    // INV and CLR
    send(4'h6, 8'h00);
    check("inv_strb", 32'(strb), 32'(S_INV));
    step();
    check("inv_acc", 32'(acc), 32'h41);
    send(4'h7, 8'h00);
    check("clr_strb", 32'(strb), 32'(S_CLR));
    step();
    check("clr_acc", 32'(acc), 32'h00);

    // Reset during the second SHIFT cycle
    send(4'hA, 8'h03);
    send(4'h8, 8'h03);
    step();
    step();
    check("rs_shift2", 32'(strb), 32'(S_LSH));
    reset = 1'b0;
    step();
    check("rs_strb",  32'(strb), 32'(S_NONE));
    check("rs_acc",   32'(acc), 32'h00);
    check("rs_ready", 32'(instr_ready), 32'd1);
    reset = 1'b1;
    step();
    check("rs_ready2", 32'(instr_ready), 32'd1);
    check("rs_acc2",   32'(acc), 32'h00);
    check("rs_strb2",  32'(strb), 32'(S_NONE));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
